// File: rtl/pu_pkg.sv
// Shared PU definitions: register-file width macros (as in pu/pu.vh) and the
// types and constants used by ra_dump.
`ifndef PU_VH
`define PU_VH
`define WIDTH 15
`define RASB 1
`define RAS 3
`endif

package pu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } ra_dump_state_t;

    localparam int RA_NREG = `RAS + 1;

endpackage

// File: rtl/ra_dump_if.sv
// Register-file read port plus valid/ready output-word stream of ra_dump.
// The out_par signal exists only when RA_DUMP_PARITY_EN is defined.
interface ra_dump_if;

    logic            start;
    logic            busy;
    logic            hold;
    logic [`RASB:0]  rd_ad;
    logic [`WIDTH:0] rd_d;
    logic            out_valid;
    logic            out_ready;
    logic [`WIDTH:0] out_data;
    logic [`RASB:0]  out_idx;
    logic [1:0]      out_pu;
    logic            out_last;
    logic            done;
`ifdef RA_DUMP_PARITY_EN
    logic            out_par;
`endif

    // master: the dump engine; slave: the PU / word consumer around it
    modport master (
        input  start, rd_d, out_ready,
        output busy, hold, rd_ad, out_valid, out_data, out_idx, out_pu, out_last,
`ifdef RA_DUMP_PARITY_EN
        output out_par,
`endif
        output done
    );

    modport slave (
        output start, rd_d, out_ready,
        input  busy, hold, rd_ad, out_valid, out_data, out_idx, out_pu, out_last,
`ifdef RA_DUMP_PARITY_EN
        input  out_par,
`endif
        input  done
    );

endinterface

// File: rtl/ra_dump_par.sv
// Even-parity reduction over one output word and its index.
// Only built when RA_DUMP_PARITY_EN is defined.
`ifdef RA_DUMP_PARITY_EN
module ra_dump_par (
    input  logic [`WIDTH:0] data,
    input  logic [`RASB:0]  idx,
    output logic            par
);

    assign par = ^{data, idx};

endmodule
`endif

// File: rtl/ra_dump.sv
// ra_dump: walks the PU register file and streams each register out over a
// valid/ready handshake. Define RA_DUMP_PARITY_EN to add the registered out_par bit.
module ra_dump
    import pu_pkg::*;
#(
    parameter logic [1:0] PU_NUM = 2'd0
) (
    input  logic      clk,
    input  logic      rst,
    ra_dump_if.master bus
);

    localparam int            IW       = `RASB + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(RA_NREG - 1);

    ra_dump_state_t  state_q, state_d;
    logic [IW-1:0]   index_q, index_d;
    logic [`WIDTH:0] out_data_q, out_data_d;
    logic [IW-1:0]   out_idx_q, out_idx_d;
    logic [1:0]      out_pu_q, out_pu_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: each combinational block assigns a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = READ;
            READ:    state_d = SEND;
            SEND:    if (bus.out_ready) state_d = (index_q == LAST_IDX) ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        index_d    = index_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        out_pu_d   = out_pu_q;
        case (state_q)
            READ: begin
                out_data_d = bus.rd_d;
                out_idx_d  = index_q;
                out_pu_d   = PU_NUM;
            end
            SEND: if (bus.out_ready && (index_q != LAST_IDX)) index_d = index_q + IW'(1);
            // IDLE and DONE: the index rests at 0 between dumps
            default: index_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q    <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_pu_q   <= '0;
        end else begin
            index_q    <= index_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            out_pu_q   <= out_pu_d;
        end
    end

`ifdef RA_DUMP_PARITY_EN
    logic par_calc;
    logic out_par_q, out_par_d;

    ra_dump_par u_par (
        .data (bus.rd_d),
        .idx  (index_q),
        .par  (par_calc)
    );

    always_comb begin
        out_par_d = out_par_q;
        if (state_q == READ) out_par_d = par_calc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_par_q <= 1'b0;
        else     out_par_q <= out_par_d;
    end
`endif

    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.hold      = (state_q != IDLE);
        bus.out_valid = (state_q == SEND);
        bus.done      = (state_q == DONE);
        bus.rd_ad     = index_q;
        bus.out_data  = out_data_q;
        bus.out_idx   = out_idx_q;
        bus.out_pu    = out_pu_q;
        bus.out_last  = (state_q == SEND) && (out_idx_q == LAST_IDX);
`ifdef RA_DUMP_PARITY_EN
        bus.out_par   = out_par_q;
`endif
    end

endmodule

// File: tb/tb_ra_dump.sv
// Self-checking bench for ra_dump: per-cycle model of the dump word stream plus
// directed scenarios (full dump, stalled consumer, ignored restart, mid-dump reset).
module tb_ra_dump;
    import pu_pkg::*;

    localparam int IW = `RASB + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ra_dump_if bus ();

    ra_dump #(.PU_NUM(2'd2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file: combinational read.
    logic [`WIDTH:0] regs [RA_NREG];
    assign bus.rd_d = regs[bus.rd_ad];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Model: a dump is RA_NREG words; each word becomes visible one cycle after
    // the start is taken or the previous word is accepted, and the cycle after
    // the last acceptance carries the done pulse.
    bit m_busy = 1'b0;
    bit m_fin  = 1'b0;
    int m_wait = 0;
    int m_idx  = 0;
    bit exp_valid;

    // Scenario observations.
    int              t_start, t_first, t_done;
    bit              first_seen;
    logic [`WIDTH:0] w_data [$];
    int              w_idx  [$];
    int              n_done, n_last, stall_cnt;
    logic            par_idx1;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_valid", bus.out_valid, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_hold", bus.hold, 0);
            check("rst_done", bus.done, 0);
            check("rst_out_data", bus.out_data, 0);
            check("rst_out_idx", bus.out_idx, 0);
            check("rst_out_pu", bus.out_pu, 0);
            check("rst_out_last", bus.out_last, 0);
`ifdef RA_DUMP_PARITY_EN
            check("rst_out_par", bus.out_par, 0);
`endif
            m_busy = 1'b0;
            m_fin  = 1'b0;
            m_wait = 0;
            m_idx  = 0;
        end else begin
            exp_valid = m_busy && !m_fin && (m_wait == 0);
            check("busy", bus.busy, m_busy);
            check("hold", bus.hold, m_busy);
            check("out_valid", bus.out_valid, exp_valid);
            check("done", bus.done, m_fin);
            if (!m_busy) check("rd_ad_idle", bus.rd_ad, 0);
            if (exp_valid) begin
                check("rd_ad", bus.rd_ad, m_idx);
                check("out_idx", bus.out_idx, m_idx);
                check("out_data", bus.out_data, regs[m_idx]);
                check("out_pu", bus.out_pu, 2);
                check("out_last", bus.out_last, m_idx == RA_NREG - 1);
`ifdef RA_DUMP_PARITY_EN
                check("out_par", bus.out_par, ^{regs[m_idx], IW'(m_idx)});
`endif
            end else begin
                check("out_last_quiet", bus.out_last, 0);
            end

            if (bus.start && !m_busy) begin
                t_start    = cyc;
                first_seen = 1'b0;
                w_data.delete();
                w_idx.delete();
                n_done     = 0;
                n_last     = 0;
                stall_cnt  = 0;
            end
            if (bus.out_valid) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    t_first    = cyc;
                end
                if (bus.out_last) n_last++;
                if (bus.out_ready) begin
                    w_data.push_back(bus.out_data);
                    w_idx.push_back(int'(bus.out_idx));
                end else begin
                    stall_cnt++;
                end
`ifdef RA_DUMP_PARITY_EN
                if (bus.out_idx == IW'(1)) par_idx1 = bus.out_par;
`endif
            end
            if (bus.done) begin
                n_done++;
                t_done = cyc;
            end

            if (!m_busy) begin
                if (bus.start) begin
                    m_busy = 1'b1;
                    m_idx  = 0;
                    m_wait = 1;
                end
            end else if (m_fin) begin
                m_busy = 1'b0;
                m_fin  = 1'b0;
                m_idx  = 0;
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (bus.out_ready) begin
                if (m_idx == RA_NREG - 1) m_fin = 1'b1;
                else begin
                    m_idx++;
                    m_wait = 1;
                end
            end
        end
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input string name, input int k);
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid && (bus.out_idx == IW'(k))) found = 1'b1;
        end
        check(name, found, 1);
    endtask

    task automatic wait_any_valid(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) found = 1'b1;
        end
        check(name, found, 1);
    endtask

    task automatic wait_done(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.done) found = 1'b1;
        end
        check(name, found, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_words(input string name);
        logic [`WIDTH:0] exp_w [RA_NREG];
        exp_w = '{16'h0002, 16'h0011, 16'h0022, 16'h0033};
        check({name, "_nwords"}, w_data.size(), 4);
        for (int i = 0; i < RA_NREG; i++) begin
            if (i < w_data.size()) begin
                check({name, "_data"}, w_data[i], exp_w[i]);
                check({name, "_idx"}, w_idx[i], i);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        regs = '{16'h0002, 16'h0011, 16'h0022, 16'h0033};
        idle(3);
        rst = 1'b0;
        idle(2);

        // out_ready pulses while idle must have no effect
        bus.out_ready = 1'b1;
        idle(2);
        bus.out_ready = 1'b0;
        idle(1);

        // Full dump with a ready consumer
        bus.out_ready = 1'b1;
        pulse_start();
        wait_done("t1_done_seen");
        idle(2);
        check("t1_first_latency", t_first - t_start, 2);
        check("t1_done_latency", t_done - t_start, 9);
        check("t1_last_count", n_last, 1);
        check("t1_done_count", n_done, 1);
        check_words("t1");

        // Consumer stalls 5 cycles on idx 1
        pulse_start();
        wait_idx("t2_idx1_seen", 1);
        bus.out_ready = 1'b0;
        idle(5);
        bus.out_ready = 1'b1;
        wait_done("t2_done_seen");
        idle(2);
        check("t2_stall_cycles", stall_cnt, 5);
        check("t2_done_latency", t_done - t_start, 14);
        check_words("t2");

        // start re-pulsed mid-dump is ignored
        pulse_start();
        wait_idx("t3_idx2_seen", 2);
        pulse_start();
        wait_done("t3_done_seen");
        idle(4);
        check("t3_done_count", n_done, 1);
        check_words("t3");

        // Reset while presenting idx 1, then a fresh dump
        pulse_start();
        wait_idx("t4_idx1_seen", 1);
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_valid", bus.out_valid, 0);
        check("t4_rst_busy", bus.busy, 0);
        check("t4_rst_done", bus.done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        check("t4_idle_valid", bus.out_valid, 0);
        pulse_start();
        wait_any_valid("t4_valid_seen");
        check("t4_first_idx", bus.out_idx, 0);
        check("t4_first_data", bus.out_data, 16'h0002);
        wait_done("t4_done_seen");
        idle(2);
        check_words("t4");

`ifdef RA_DUMP_PARITY_EN
        regs = '{16'h0000, 16'h0003, 16'h0000, 16'h0000};
        pulse_start();
        wait_done("t5a_done_seen");
        idle(2);
        check("t5_par_data3_idx1", par_idx1, 1);
        regs = '{16'h0000, 16'h0001, 16'h0000, 16'h0000};
        pulse_start();
        wait_done("t5b_done_seen");
        idle(2);
        check("t5_par_data1_idx1", par_idx1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ra_dump.md
RA_DUMP -- requirements
Module: ra_dump

Interface
REQ-001 SHALL have parameter PU_NUM, default 0: 2-bit processing-unit number copied onto every output word.
REQ-002 SHALL have clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have start  input  1  dump request; sampled only in IDLE.
REQ-005 SHALL have busy  output  1  high in every state except IDLE.
REQ-006 SHALL have hold  output  1  equal to busy; the PU gates its register-file write enable with it.
REQ-007 SHALL have rd_ad  output  `RASB+1  register-file read address.
REQ-008 SHALL have rd_d  input  `WIDTH+1  register-file read data, combinational from rd_ad.
REQ-009 SHALL have out_valid  output  1 / out_ready  input  1  output word handshake.
REQ-010 SHALL have out_data  output  `WIDTH+1, out_idx  output  `RASB+1, out_pu  output  2, out_last  output  1.
REQ-011 SHALL have done  output  1  single-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, READ, SEND, DONE.
REQ-013 IDLE: start=1 -> READ, index cleared to 0; otherwise stay.
REQ-014 READ: rd_ad=index; next edge captures rd_d into out_data, index into out_idx, PU_NUM into out_pu -> SEND.
REQ-015 rd_ad SHALL equal the index in every state; index value 0 outside a dump.
REQ-016 SEND: out_valid=1; out_data/out_idx/out_pu/out_last SHALL stay stable until out_valid and out_ready are both high.
REQ-017 On transfer in SEND: if index = `RAS -> DONE, else index+1 -> READ.
REQ-018 out_last SHALL be 1 exactly while out_valid=1 and out_idx = `RAS.
REQ-019 DONE: done=1 for that one cycle -> IDLE.
REQ-020 Latency: first out_valid 2 cycles after start is sampled; with out_ready held high each word takes 2 cycles, and done rises 2*(`RAS+1)+1 cycles after start.
REQ-021 start while busy SHALL be ignored; no queueing.
REQ-022 out_ready while out_valid=0 SHALL have no effect.
REQ-023 out_ready low indefinitely SHALL hold SEND with no timeout.
REQ-024 Index arithmetic is `RASB+1 bits wide and never wraps past `RAS.

Reset
REQ-025 On rst: state IDLE, index 0, out_valid 0, done 0, busy/hold 0, out_data/out_idx/out_pu/out_last 0.
REQ-026 rst mid-dump SHALL abort immediately; after release no stale word is presented and a new start begins again at index 0.

Configuration
REQ-027 Macro RA_DUMP_PARITY_EN defined: SHALL add output out_par 1, even parity over {out_data,out_idx}, registered with out_data; reset value 0.
REQ-028 Macro undefined: out_par port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package pu_pkg SHALL hold typedef ra_dump_state_t (IDLE, READ, SEND, DONE) and constant RA_NREG = `RAS+1.
REQ-030 Width macros `WIDTH, `RASB, `RAS SHALL come from pu/pu.vh.
REQ-031 Sub-module ra_dump_par (parity reduction) SHALL be instantiated only under RA_DUMP_PARITY_EN; no other sub-modules.

Verification
REQ-032 PU_NUM=2, regs {2,0x11,0x22,0x33}, out_ready=1, start pulse -> words idx 0..3 data 2,0x11,0x22,0x33, out_pu=2, out_last only on idx 3, done 9 cycles after start.
REQ-033 Same dump, out_ready low 5 cycles at idx 1 -> out_data 0x11 and out_idx 1 stable all 5 cycles, then sequence continues unchanged.
REQ-034 start re-pulsed at idx 2 -> ignored; exactly 4 words and one done pulse.
REQ-035 rst asserted at SEND idx 1 -> out_valid, busy, done 0 next sample; a new start yields idx 0 first.
REQ-036 RA_DUMP_PARITY_EN, out_data=0x0003, out_idx=1 -> out_par=1; out_data=0x0001, out_idx=1 -> out_par=0.
REQ-037 hold=1 from start sample through DONE, 0 in IDLE.
